// File: rtl/joint_pwmdir_multi.sv
// joint_pwmdir_multi
// Multi-channel PWM/DIR H-bridge driver. All channels share one period
// counter; each channel latches its duty command at the period boundary so
// the applied duty never changes mid-period. A direction reversal runs a
// two-phase dead-time sequence before PWM resumes:
//   BRAKE  (PWM off, old DIR held)
//   SWITCH (PWM off, new DIR applied)
//
// Ports:
//   clk                 system clock
//   reset               synchronous active-high reset
//   jointEnable[N]      per-channel enable
//   jointFreqCmd[32N]   signed duty command, channel i at [32*i+31:32*i]
//   jointFeedback[32N]  signed applied duty, same packing
//   DIR[N]              direction pin, 1 = positive
//   PWM[N]              PWM pin
//
// Optional build macro JOINT_PWMDIR_FAULT_EN adds the following ports:
//   jointFault[N]         asynchronous active-high fault input
//   jointFaultLatched[N]  sticky fault flag
// It clears only while the channel is disabled and the fault is gone.
module joint_pwmdir_multi #(
  parameter int NUM_CH      = 4,
  parameter int PWM_PERIOD  = 100000,
  parameter int DEAD_CYCLES = 50
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     jointEnable,
  input  logic [32*NUM_CH-1:0]  jointFreqCmd,
`ifdef JOINT_PWMDIR_FAULT_EN
  input  logic [NUM_CH-1:0]     jointFault,
  output logic [NUM_CH-1:0]     jointFaultLatched,
`endif
  output logic [32*NUM_CH-1:0]  jointFeedback,
  output logic [NUM_CH-1:0]     DIR,
  output logic [NUM_CH-1:0]     PWM
);

  localparam int CW  = $clog2(PWM_PERIOD);
  // The duty register must be able to hold PWM_PERIOD itself (always-on).
  localparam int DW  = $clog2(PWM_PERIOD + 1);
  localparam int DCW = $clog2(DEAD_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(PWM_PERIOD - 1);
  localparam logic [DCW-1:0] DC_INIT  = DCW'(DEAD_CYCLES - 1);

  typedef enum logic [1:0] {ST_RUN, ST_BRAKE, ST_SWITCH} state_t;

  logic [CW-1:0] cnt_reg;
  logic          boundary;

  assign boundary = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= boundary ? '0 : cnt_reg + CW'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t          state_reg;
      logic [DW-1:0]   duty_reg;
      logic            dir_reg;
      logic            tgt_reg;
      logic [DCW-1:0]  dc_reg;
      logic            pwm_reg;
      logic [31:0]     fb_reg;

      logic            en;
      logic [31:0]     cmd;
      logic [32:0]     cmd_ext;
      logic [32:0]     abs_val;
      logic [DW-1:0]   duty_clamped;
      logic            cmd_nz;
      logic            req_dir;
      logic            fault_sync;
      logic            fault_latched;
      logic            fault_block;

      assign en  = jointEnable[gi];
      assign cmd = jointFreqCmd[32*gi +: 32];

      // Magnitude in 33 bits so that -2^31 becomes +2^31 rather than wrapping.
      always_comb begin
        cmd_ext      = {cmd[31], cmd};
        abs_val      = cmd[31] ? (33'd0 - cmd_ext) : cmd_ext;
        duty_clamped = (abs_val > 33'(PWM_PERIOD)) ? DW'(PWM_PERIOD) : abs_val[DW-1:0];
        cmd_nz       = (cmd != 32'd0);
        // A zero command keeps the present direction.
        req_dir      = cmd_nz ? ~cmd[31] : dir_reg;
      end

`ifdef JOINT_PWMDIR_FAULT_EN
      logic fault_meta_reg;
      logic fault_sync_reg;
      logic fault_latched_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          fault_meta_reg    <= 1'b0;
          fault_sync_reg    <= 1'b0;
          fault_latched_reg <= 1'b0;
        end else begin
          fault_meta_reg <= jointFault[gi];
          fault_sync_reg <= fault_meta_reg;
          if (fault_sync_reg) begin
            fault_latched_reg <= 1'b1;
          end else if (!en) begin
            fault_latched_reg <= 1'b0;
          end
        end
      end

      assign fault_sync            = fault_sync_reg;
      assign fault_latched         = fault_latched_reg;
      assign jointFaultLatched[gi] = fault_latched_reg;
`else
      assign fault_sync    = 1'b0;
      assign fault_latched = 1'b0;
`endif

      assign fault_block = fault_sync | fault_latched;

      always_ff @(posedge clk) begin
        if (reset) begin
          state_reg <= ST_RUN;
          duty_reg  <= '0;
          dir_reg   <= 1'b0;
          tgt_reg   <= 1'b0;
          dc_reg    <= '0;
          pwm_reg   <= 1'b0;
          fb_reg    <= '0;
        end else begin
          // Outputs are registered from the pre-edge state and counter,
          // giving one cycle of latency from cnt to the pin.
          pwm_reg <= (state_reg == ST_RUN) && en && !fault_block &&
                     (33'(cnt_reg) < 33'(duty_reg));
          if ((state_reg == ST_RUN) && en && !fault_block) begin
            fb_reg <= dir_reg ? 32'(duty_reg) : (32'd0 - 32'(duty_reg));
          end else begin
            fb_reg <= '0;
          end

          if (fault_sync) begin
            state_reg <= ST_RUN;
            duty_reg  <= '0;
          end else if (!en) begin
            // Disabling aborts any dead-time sequence; DIR stays where it is.
            state_reg <= ST_RUN;
            if (boundary) begin
              duty_reg <= '0;
            end
          end else begin
            case (state_reg)
              ST_RUN: begin
                if (boundary && !fault_latched) begin
                  if (cmd_nz && (req_dir != dir_reg)) begin
                    duty_reg  <= '0;
                    tgt_reg   <= req_dir;
                    dc_reg    <= DC_INIT;
                    state_reg <= ST_BRAKE;
                  end else begin
                    duty_reg <= duty_clamped;
                  end
                end
              end
              ST_BRAKE: begin
                if (dc_reg == '0) begin
                  dir_reg   <= tgt_reg;
                  dc_reg    <= DC_INIT;
                  state_reg <= ST_SWITCH;
                end else begin
                  dc_reg <= dc_reg - DCW'(1);
                end
              end
              ST_SWITCH: begin
                if (dc_reg == '0) begin
                  duty_reg  <= '0;
                  state_reg <= ST_RUN;
                end else begin
                  dc_reg <= dc_reg - DCW'(1);
                end
              end
              default: state_reg <= ST_RUN;
            endcase
          end
        end
      end

      assign PWM[gi]                   = pwm_reg;
      assign DIR[gi]                   = dir_reg;
      assign jointFeedback[32*gi +: 32] = fb_reg;
    end
  endgenerate

endmodule

// File: tb/tb_joint_pwmdir_multi.sv
// Testbench for joint_pwmdir_multi (NUM_CH=4, PWM_PERIOD=10, DEAD_CYCLES=3).
// A timestamp-based behavioural model predicts PWM/DIR/jointFeedback on every
// edge; a compare process checks all channels each cycle. Directed steps on
// channel 0 pin the model with literal expectations, then randomized commands
// and enables exercise all channels.
module tb_joint_pwmdir_multi;
  localparam int NCH = 4;
  localparam int P   = 10;
  localparam int D   = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic [NCH-1:0]      en;
  logic [32*NCH-1:0]   cmd;
  logic [32*NCH-1:0]   fb;
  logic [NCH-1:0]      dir;
  logic [NCH-1:0]      pwm;

  int tests = 0;
  int fails = 0;
  int printed = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  joint_pwmdir_multi #(.NUM_CH(NCH), .PWM_PERIOD(P), .DEAD_CYCLES(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .jointEnable  (en),
    .jointFreqCmd (cmd),
    .jointFeedback(fb),
    .DIR          (dir),
    .PWM          (pwm)
  );

  // ---------------- behavioural model ----------------
  // Dead time is tracked as "edge index when it started"; DIR flips D edges
  // after that and PWM may resume 2*D edges after it.
  int     m_duty [NCH];
  bit     m_dir  [NCH];
  bit     m_dead [NCH];
  bit     m_tgt  [NCH];
  longint m_e0   [NCH];
  longint m_edges;
  bit     e_pwm  [NCH];
  bit     e_dir  [NCH];
  int     e_fb   [NCH];

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        for (int ch = 0; ch < NCH; ch++) begin
          m_duty[ch] = 0; m_dir[ch] = 0; m_dead[ch] = 0; m_tgt[ch] = 0;
          m_e0[ch] = 0; e_pwm[ch] = 0; e_dir[ch] = 0; e_fb[ch] = 0;
        end
        m_edges = 0;
      end else begin
        int  c;
        bit  bnd;
        c   = int'(m_edges % P);
        bnd = (c == P - 1);
        for (int ch = 0; ch < NCH; ch++) begin
          int     cv;
          longint a;
          longint el;
          bit     run;
          cv  = $signed(cmd[32*ch +: 32]);
          run = !m_dead[ch];
          e_pwm[ch] = run && en[ch] && (c < m_duty[ch]);
          e_fb[ch]  = (run && en[ch]) ? (m_dir[ch] ? m_duty[ch] : -m_duty[ch]) : 0;
          if (!en[ch]) begin
            m_dead[ch] = 0;
            if (bnd) m_duty[ch] = 0;
          end else if (m_dead[ch]) begin
            el = m_edges - m_e0[ch];
            if (el == D) m_dir[ch] = m_tgt[ch];
            if (el == 2 * D) begin
              m_dead[ch] = 0;
              m_duty[ch] = 0;
            end
          end else if (bnd) begin
            if (cv != 0 && ((cv > 0) != m_dir[ch])) begin
              m_dead[ch] = 1;
              m_tgt[ch]  = (cv > 0);
              m_e0[ch]   = m_edges;
              m_duty[ch] = 0;
            end else begin
              a = cv;
              if (a < 0) a = -a;
              if (a > P) a = P;
              m_duty[ch] = int'(a);
            end
          end
          e_dir[ch] = m_dir[ch];
        end
        m_edges++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int ch = 0; ch < NCH; ch++) begin
        tests++;
        if (pwm[ch] !== e_pwm[ch] || dir[ch] !== e_dir[ch] ||
            $signed(fb[32*ch +: 32]) !== e_fb[ch]) begin
          fails++;
          if (printed < 40) begin
            printed++;
            $display("FAIL cycle ch%0d t=%0t: pwm/dir/fb got %b/%b/%0d expected %b/%b/%0d",
                     ch, $time, pwm[ch], dir[ch], $signed(fb[32*ch +: 32]),
                     e_pwm[ch], e_dir[ch], e_fb[ch]);
          end
        end
      end
    end
  end

  task automatic check_lit(input string name, input logic signed [63:0] act,
                           input logic signed [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_cmd(input int ch, input logic [31:0] v);
    cmd[32*ch +: 32] = v;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts PWM0 highs over one full period.
  task automatic pwm0_count(output int n);
    n = 0;
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      if (pwm[0] === 1'b1) n++;
    end
  endtask

  function automatic logic [31:0] rand_cmd();
    int v;
    case ($urandom_range(0, 5))
      0: v = 0;
      1: v = 32'h8000_0000;
      2: v = int'($urandom_range(11, 5000));
      3: v = -int'($urandom_range(11, 5000));
      default: v = int'($urandom_range(0, 24)) - 12;
    endcase
    return 32'(v);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bit seen;
    reset = 1'b1;
    en    = '0;
    cmd   = '0;
    wait_cyc(3);
    check_lit("reset_pwm", pwm, 0);
    check_lit("reset_dir", dir, 0);
    check_lit("reset_fb",  fb[63:0], 0);

    // Channels 1..3 run random commands in the background.
    for (int ch = 1; ch < NCH; ch++) begin
      set_cmd(ch, rand_cmd());
      en[ch] = 1'b1;
    end
    set_cmd(0, 32'd4);
    en[0] = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;

    // +4 from reset (DIR=0) goes through dead time, then duty 4.
    wait_cyc(30);
    check_lit("p4_dir", dir[0], 1);
    check_lit("p4_fb", $signed(fb[31:0]), 4);
    pwm0_count(n);
    check_lit("p4_highs", n, 4);

    // Reversal mid-period.
    wait_cyc(3);
    set_cmd(0, -32'sd4);
    wait_cyc(30);
    check_lit("m4_dir", dir[0], 0);
    check_lit("m4_fb", $signed(fb[31:0]), -4);

    // Clamp at +PWM_PERIOD.
    set_cmd(0, 32'd20);
    wait_cyc(30);
    check_lit("p20_fb", $signed(fb[31:0]), 10);
    pwm0_count(n);
    check_lit("p20_highs", n, 10);

    // Most negative command.
    set_cmd(0, 32'h8000_0000);
    wait_cyc(30);
    check_lit("min_fb", $signed(fb[31:0]), -10);
    check_lit("min_dir", dir[0], 0);
    pwm0_count(n);
    check_lit("min_highs", n, 10);

    // -3 then 0: direction kept, no dead time.
    set_cmd(0, -32'sd3);
    wait_cyc(30);
    check_lit("m3_fb", $signed(fb[31:0]), -3);
    set_cmd(0, 32'd0);
    wait_cyc(20);
    check_lit("zero_dir", dir[0], 0);
    check_lit("zero_fb", $signed(fb[31:0]), 0);
    pwm0_count(n);
    check_lit("zero_highs", n, 0);

    // Enable drop during BRAKE.
    set_cmd(0, 32'd3);
    seen = 1'b0;
    for (int i = 0; i < 3 * P; i++) begin
      @(negedge clk);
      if (m_dead[0]) begin
        seen = 1'b1;
        break;
      end
    end
    check_lit("brake_reached", seen, 1);
    en[0] = 1'b0;
    @(negedge clk);
    check_lit("abort_pwm", pwm[0], 0);
    check_lit("abort_dir", dir[0], 0);
    wait_cyc(12);
    en[0] = 1'b1;
    wait_cyc(30);
    check_lit("reen_dir", dir[0], 1);
    check_lit("reen_fb", $signed(fb[31:0]), 3);

    // Randomized phase, with a mid-run reset.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if ($urandom_range(0, 39) == 0) set_cmd(ch, rand_cmd());
        if ($urandom_range(0, 149) == 0) en[ch] = ~en[ch];
      end
      if (cyc == 1503) reset = 1'b1;
      if (cyc == 1505) begin
        check_lit("midreset_pwm", pwm, 0);
        check_lit("midreset_fb", fb[63:0], 0);
        reset = 1'b0;
      end
      @(negedge clk);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
